ul_i2c_arb: RTL and testbench
=============================

Name: ul_i2c_arb

Overview:
- Shares one ul_i2c_dme command/readback/interrupt interface among 4 requesters, e.g. host register path, temperature poller, PMIC/clock-gen init sequencer.
- Round-robin arbitration. A grant is held for the whole I2C transaction, until its write completes, its read data returns, or a timeout fires.
- Each requester gets a per-transaction completion pulse, the 32-bit readback word and an error flag.
- Sits between the requesters and ul_i2c_dme, in the same clk domain.

Parameters:
- NREQ, 4: number of requesters. Fixed at 4; the grant index is 2 bits.
- TMO_BITS, 24: timeout counter width. The timeout fires after 2^TMO_BITS - 1 cycles in a wait state (about 134 ms at 125 MHz).
- RD_BIT, 31: bit of the command word that marks a read-after-write transaction.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  4  per-requester command valid
- req_data  in  128  per-requester 32-bit command word; requester i uses bits [32i+31:32i]; format is the DME command format
- req_ready  out  4  one-hot accept strobe
- req_done  out  4  one-hot, 1-cycle completion pulse
- req_err  out  1  error status, valid with req_done (timeout, or readback 0xFFFFFFFF on a read)
- req_rdata  out  32  readback word, valid with req_done
- axis_cmdreg_valid  out  1  command to DME
- axis_cmdreg_data  out  32  command to DME
- axis_cmdreg_ready  in  1  DME idle/accept
- axis_rbdata_data  in  32  DME readback register
- int_valid  in  1  DME read-completion flag
- int_ready  out  1  DME read-completion acknowledge
- busy  out  1  state != ST_IDLE
- cur_grant  out  2  index of the active requester

Behaviour:

Reset:
- State goes to ST_IDLE, last grant = 3 (so requester 0 has priority first).
- req_done = 0, req_err = 0, req_rdata = 0.
- axis_cmdreg_valid = 0, timeout counter = 0.
- Reset mid-transaction abandons the grant with no req_done pulse. ul_i2c_dme shares the same reset.

Arbitration (ST_IDLE):
- Combinational search from last_grant+1 upward, mod 4, for the first set req_valid bit.
- req_ready is one-hot on the winner in the same cycle, and only in ST_IDLE.
- On acceptance: register req_data into cmd_reg and the winner into grant/last_grant; go to ST_ISSUE.
- No req_valid set: stay in ST_IDLE, req_ready = 0.

ST_ISSUE:
- axis_cmdreg_valid = 1, axis_cmdreg_data = cmd_reg.
- On valid && ready: go to ST_WAIT_RD if cmd_reg[RD_BIT] is set, otherwise ST_WAIT_WR. Clear the timeout counter.

ST_WAIT_WR:
- Ignore axis_cmdreg_ready for the first cycle after acceptance, because DME ready drops one cycle late.
- From then on, axis_cmdreg_ready == 1 means done: go to ST_DONE with err = 0, rdata = 0.

ST_WAIT_RD:
- int_ready = 1.
- On int_valid: capture axis_rbdata_data into req_rdata; err = (data == 32'hFFFFFFFF); go to ST_DONE.

Timeout:
- The counter increments every cycle in ST_WAIT_WR and ST_WAIT_RD.
- At all-ones: go to ST_DONE with err = 1 and rdata = 32'hFFFFFFFF.

ST_DONE (1 cycle):
- req_done[grant] = 1 together with req_err and req_rdata. Next state ST_IDLE.
- req_rdata and req_err hold their value until the next ST_DONE.

Stale interrupts:
- int_ready = 1 also in ST_IDLE, so a late int_valid from a timed-out read is drained and discarded.
- int_ready = 0 in ST_ISSUE, ST_WAIT_WR and ST_DONE.

Simultaneous events:
- A requester may hold req_valid continuously; it gets at most one grant per round when others are requesting.
- Back-to-back transactions have a minimum of 2 idle cycles between DME commands (ST_DONE, then ST_IDLE).
- req_valid dropping before req_ready is allowed; no transaction is started for it.

Width rules:
- The timeout counter saturates and never wraps.
- The round-robin pointer wraps modulo 4.

Decomposition:
- Shared package ul_i2c_pkg:
  - command field offsets: RDVAL = 31, RDSZ = 28, WRSZ = 26, DEVNO = 24
  - state encodings: ST_IDLE, ST_ISSUE, ST_WAIT_WR, ST_WAIT_RD, ST_DONE
  - constant I2C_ERR_WORD = 32'hFFFFFFFF
- One natural sub-module, ul_rr_arb4: combinational round-robin priority picker, inputs req[3:0] and last[1:0], outputs gnt_onehot[3:0], gnt_idx[1:0], any.

Test Plan:
- Single write: req_valid[1] with data 0x0C123456 (WRSZ = 3, no read); DME ready goes 1→0→1 → one command out, axis_cmdreg_data = 0x0C123456, req_done = 4'b0010, req_err = 0.
- Single read: req_valid[2] with 0x94000010; DME asserts int_valid 200 cycles later with rbdata = 0x000000AB → req_done = 4'b0100, req_rdata = 0x000000AB, int_ready high that cycle, req_err = 0.
- Round-robin: all 4 req_valid held high after reset → grant order 0,1,2,3,0; no requester is granted twice while others wait; exactly one DME command per grant.
- Timeout: TMO_BITS = 8; read issued, int_valid never comes → req_done after 255 wait cycles, req_err = 1, req_rdata = 0xFFFFFFFF; a later stray int_valid is acknowledged in ST_IDLE and no req_done is produced.
- Error readback: int_valid with rbdata = 0xFFFFFFFF → req_err = 1.
- Reset mid-transaction: reset asserted in ST_WAIT_RD → next cycle busy = 0, axis_cmdreg_valid = 0, req_done = 0; a new request after reset is granted to requester 0 first.

Source files
------------

// File: rtl/ul_i2c_pkg.sv
// -----------------------------------------------------------------------------
// ul_i2c_pkg
//   Shared definitions for the I2C DME command path: command-word field
//   offsets, arbiter FSM state encoding, the error/readback sentinel word and
//   a small index-to-one-hot helper.
// -----------------------------------------------------------------------------
package ul_i2c_pkg;

    // Command word field offsets (DME command format)
    localparam int RDVAL = 31;  // read-after-write transaction
    localparam int RDSZ  = 28;
    localparam int WRSZ  = 26;
    localparam int DEVNO = 24;

    // Readback word that signals a failed transaction
    localparam logic [31:0] I2C_ERR_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_WR,
        ST_WAIT_RD,
        ST_DONE
    } arb_state_e;

    function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/ul_i2c_arb_rr.sv
// -----------------------------------------------------------------------------
// ul_rr_arb4
//   Combinational 4-way round-robin picker. The search starts at last+1 and
//   wraps modulo 4, so the most recently served requester has lowest priority.
//
//   req        in  4  request vector
//   last       in  2  index of the previous winner
//   gnt_onehot out 4  one-hot winner (all zero when no request)
//   gnt_idx    out 2  winner index (0 when no request)
//   any        out 1  at least one request present
// -----------------------------------------------------------------------------
module ul_rr_arb4
    import ul_i2c_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [3:0] gnt_onehot,
    output logic [1:0] gnt_idx,
    output logic       any
);

    logic [1:0] cand;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        gnt_idx = 2'd0;
        any     = 1'b0;
        cand    = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            cand = last + i[1:0];  // 2-bit add wraps modulo 4
            if (!any && req[cand]) begin
                any     = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt_onehot = any ? idx_to_onehot(gnt_idx) : 4'b0000;
    end

endmodule

// File: rtl/ul_i2c_arb.sv
// -----------------------------------------------------------------------------
// ul_i2c_arb
//   Shares one ul_i2c_dme command/readback/interrupt interface among four
//   requesters. Round-robin grant, held for the whole I2C transaction (write
//   completion, read data return, or timeout).
//
//   clk               in   1    system clock
//   reset             in   1    synchronous active-high reset
//   req_valid         in   4    per-requester command valid
//   req_data          in   128  per-requester command word, [32i+31:32i]
//   req_ready         out  4    one-hot accept strobe (ST_IDLE only)
//   req_done          out  4    one-hot 1-cycle completion pulse
//   req_err           out  1    error status, valid with req_done
//   req_rdata         out  32   readback word, valid with req_done
//   axis_cmdreg_valid out  1    command to DME
//   axis_cmdreg_data  out  32   command to DME
//   axis_cmdreg_ready in   1    DME idle/accept
//   axis_rbdata_data  in   32   DME readback register
//   int_valid         in   1    DME read-completion flag
//   int_ready         out  1    DME read-completion acknowledge
//   busy              out  1    FSM not idle
//   cur_grant         out  2    index of the active requester
// -----------------------------------------------------------------------------
module ul_i2c_arb
    import ul_i2c_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int TMO_BITS = 24,
    parameter int RD_BIT   = RDVAL
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      req_done,
    output logic                 req_err,
    output logic [31:0]          req_rdata,
    output logic                 axis_cmdreg_valid,
    output logic [31:0]          axis_cmdreg_data,
    input  logic                 axis_cmdreg_ready,
    input  logic [31:0]          axis_rbdata_data,
    input  logic                 int_valid,
    output logic                 int_ready,
    output logic                 busy,
    output logic [1:0]           cur_grant
);

    localparam logic [TMO_BITS-1:0] TMO_MAX = '1;

    arb_state_e          state_q, state_d;
    logic [1:0]          last_q,  last_d;
    logic [1:0]          grant_q, grant_d;
    logic [31:0]         cmd_q,   cmd_d;
    logic [TMO_BITS-1:0] tmo_q,   tmo_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q,   err_d;

    logic [3:0]          arb_onehot;
    logic [1:0]          arb_idx;
    logic                arb_any;
    logic [TMO_BITS-1:0] tmo_inc;
    logic                tmo_fire;

    ul_rr_arb4 u_rr (
        .req        (req_valid),
        .last       (last_q),
        .gnt_onehot (arb_onehot),
        .gnt_idx    (arb_idx),
        .any        (arb_any)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        cmd_d   = cmd_q;
        tmo_d   = tmo_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        // Saturating increment; the timeout fires as the count reaches
        // all-ones, i.e. after 2^TMO_BITS-1 cycles in a wait state.
        tmo_inc  = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_BITS'(1);
        tmo_fire = (tmo_inc == TMO_MAX);

        unique case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    cmd_d   = req_data[32*arb_idx +: 32];
                    grant_d = arb_idx;
                    last_d  = arb_idx;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (axis_cmdreg_ready) begin
                    tmo_d   = '0;
                    state_d = cmd_q[RD_BIT] ? ST_WAIT_RD : ST_WAIT_WR;
                end
            end
            ST_WAIT_WR: begin
                tmo_d = tmo_inc;
                // tmo_q == 0 only in the first wait cycle: DME ready is still
                // high from the accept and drops one cycle late.
                if (tmo_q != '0 && axis_cmdreg_ready) begin
                    state_d = ST_DONE;
                    err_d   = 1'b0;
                    rdata_d = '0;
                end else if (tmo_fire) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                    rdata_d = I2C_ERR_WORD;
                end
            end
            ST_WAIT_RD: begin
                tmo_d = tmo_inc;
                if (int_valid) begin
                    state_d = ST_DONE;
                    err_d   = (axis_rbdata_data == I2C_ERR_WORD);
                    rdata_d = axis_rbdata_data;
                end else if (tmo_fire) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                    rdata_d = I2C_ERR_WORD;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= 2'd3;  // requester 0 is searched first
            grant_q <= 2'd0;
            cmd_q   <= '0;
            tmo_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            cmd_q   <= cmd_d;
            tmo_q   <= tmo_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign busy              = (state_q != ST_IDLE);
    assign cur_grant         = grant_q;
    assign axis_cmdreg_valid = (state_q == ST_ISSUE);
    assign axis_cmdreg_data  = cmd_q;
    // Ready in ST_IDLE too, so a late interrupt from a timed-out read is drained.
    assign int_ready         = (state_q == ST_IDLE) || (state_q == ST_WAIT_RD);
    assign req_ready         = (state_q == ST_IDLE) ? arb_onehot : '0;
    assign req_done          = (state_q == ST_DONE) ? idx_to_onehot(grant_q) : '0;
    assign req_err           = err_q;
    assign req_rdata         = rdata_q;

endmodule

// File: tb/tb_ul_i2c_arb.sv
// -----------------------------------------------------------------------------
// tb_ul_i2c_arb
//   Directed bench for ul_i2c_arb with an 8-bit timeout counter. The bench
//   plays the DME side by hand. Inputs change and outputs are sampled on the
//   falling edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_ul_i2c_arb;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic [3:0]   req_done;
    logic         req_err;
    logic [31:0]  req_rdata;
    logic         axis_cmdreg_valid;
    logic [31:0]  axis_cmdreg_data;
    logic         axis_cmdreg_ready;
    logic [31:0]  axis_rbdata_data;
    logic         int_valid;
    logic         int_ready;
    logic         busy;
    logic [1:0]   cur_grant;

    int n_checks = 0;
    int n_fail   = 0;
    int cmd_cnt  = 0;

    always #5 clk = ~clk;

    ul_i2c_arb #(.TMO_BITS(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_data          (req_data),
        .req_ready         (req_ready),
        .req_done          (req_done),
        .req_err           (req_err),
        .req_rdata         (req_rdata),
        .axis_cmdreg_valid (axis_cmdreg_valid),
        .axis_cmdreg_data  (axis_cmdreg_data),
        .axis_cmdreg_ready (axis_cmdreg_ready),
        .axis_rbdata_data  (axis_rbdata_data),
        .int_valid         (int_valid),
        .int_ready         (int_ready),
        .busy              (busy),
        .cur_grant         (cur_grant)
    );

    // Commands handed to the DME (handshake seen at the accepting edge)
    always @(posedge clk) if (axis_cmdreg_valid && axis_cmdreg_ready) cmd_cnt++;

    task automatic test_reset();
        reset = 1'b1; req_valid = '0; req_data = '0; axis_cmdreg_ready = 1'b0;
        axis_rbdata_data = '0; int_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0h want 0", busy); end
        n_checks++; if (axis_cmdreg_valid !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_valid: got %0h want 0", axis_cmdreg_valid); end
        n_checks++; if (req_done !== 4'b0000) begin n_fail++; $display("FAIL rst_done: got %b want 0000", req_done); end
        n_checks++; if (req_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %0h want 0", req_err); end
        n_checks++; if (req_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", req_rdata); end
        n_checks++; if (int_ready !== 1'b1) begin n_fail++; $display("FAIL rst_int_ready: got %0h want 1", int_ready); end
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_idle_ready: got %b want 0000", req_ready); end
    endtask

    // Read on requester 2; interrupt 200 cycles after the DME takes the command
    task automatic test_single_read();
        logic stray;
        req_data[95:64] = 32'h9400_0010; req_valid = 4'b0100; axis_cmdreg_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL rd_req_ready: got %b want 0100", req_ready); end
        @(negedge clk); req_valid = '0;
        n_checks++; if (axis_cmdreg_valid !== 1'b1) begin n_fail++; $display("FAIL rd_cmd_valid: got %0h want 1", axis_cmdreg_valid); end
        n_checks++; if (axis_cmdreg_data !== 32'h9400_0010) begin n_fail++; $display("FAIL rd_cmd_data: got %h want 94000010", axis_cmdreg_data); end
        n_checks++; if (cur_grant !== 2'd2) begin n_fail++; $display("FAIL rd_grant: got %0d want 2", cur_grant); end
        n_checks++; if (int_ready !== 1'b0) begin n_fail++; $display("FAIL rd_issue_int_ready: got %0h want 0", int_ready); end
        @(negedge clk); axis_cmdreg_ready = 1'b0;
        n_checks++; if (int_ready !== 1'b1) begin n_fail++; $display("FAIL rd_wait_int_ready: got %0h want 1", int_ready); end
        n_checks++; if (axis_cmdreg_valid !== 1'b0) begin n_fail++; $display("FAIL rd_wait_cmd_valid: got %0h want 0", axis_cmdreg_valid); end
        stray = 1'b0;
        repeat (199) begin @(negedge clk); if (req_done !== 4'b0000) stray = 1'b1; end
        n_checks++; if (stray !== 1'b0) begin n_fail++; $display("FAIL rd_early_done: got %0h want 0", stray); end
        axis_rbdata_data = 32'h0000_00AB; int_valid = 1'b1;
        #1;
        n_checks++; if (int_ready !== 1'b1) begin n_fail++; $display("FAIL rd_ack: got %0h want 1", int_ready); end
        @(negedge clk); int_valid = 1'b0;
        n_checks++; if (req_done !== 4'b0100) begin n_fail++; $display("FAIL rd_done: got %b want 0100", req_done); end
        n_checks++; if (req_rdata !== 32'h0000_00AB) begin n_fail++; $display("FAIL rd_rdata: got %h want 000000ab", req_rdata); end
        n_checks++; if (req_err !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %0h want 0", req_err); end
        @(negedge clk);
        n_checks++; if (req_done !== 4'b0000) begin n_fail++; $display("FAIL rd_done_pulse: got %b want 0000", req_done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_idle: got %0h want 0", busy); end
        n_checks++; if (req_rdata !== 32'h0000_00AB) begin n_fail++; $display("FAIL rd_rdata_hold: got %h want 000000ab", req_rdata); end
    endtask

    // Read on requester 3 returning the error word
    task automatic test_error_readback();
        req_data[127:96] = 32'h9400_0030; req_valid = 4'b1000; axis_cmdreg_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL er_req_ready: got %b want 1000", req_ready); end
        @(negedge clk); req_valid = '0;
        @(negedge clk); axis_cmdreg_ready = 1'b0;
        repeat (4) @(negedge clk);
        axis_rbdata_data = 32'hFFFF_FFFF; int_valid = 1'b1;
        @(negedge clk); int_valid = 1'b0;
        n_checks++; if (req_done !== 4'b1000) begin n_fail++; $display("FAIL er_done: got %b want 1000", req_done); end
        n_checks++; if (req_err !== 1'b1) begin n_fail++; $display("FAIL er_err: got %0h want 1", req_err); end
        n_checks++; if (req_rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL er_rdata: got %h want ffffffff", req_rdata); end
        @(negedge clk);
    endtask

    // Write on requester 1; DME ready stays high one cycle after accept, then 0, then 1
    task automatic test_single_write();
        int cnt0;
        cnt0 = cmd_cnt;
        req_data[63:32] = 32'h0C12_3456; req_valid = 4'b0010; axis_cmdreg_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL wr_req_ready: got %b want 0010", req_ready); end
        @(negedge clk); req_valid = '0;
        n_checks++; if (axis_cmdreg_data !== 32'h0C12_3456) begin n_fail++; $display("FAIL wr_cmd_data: got %h want 0c123456", axis_cmdreg_data); end
        n_checks++; if (cur_grant !== 2'd1) begin n_fail++; $display("FAIL wr_grant: got %0d want 1", cur_grant); end
        @(negedge clk);
        n_checks++; if (axis_cmdreg_valid !== 1'b0) begin n_fail++; $display("FAIL wr_wait_cmd_valid: got %0h want 0", axis_cmdreg_valid); end
        @(negedge clk); axis_cmdreg_ready = 1'b0;
        // Stale ready in the first wait cycle must not complete the write
        n_checks++; if (req_done !== 4'b0000) begin n_fail++; $display("FAIL wr_ignore_stale_ready: got %b want 0000", req_done); end
        repeat (2) @(negedge clk);
        n_checks++; if (req_done !== 4'b0000) begin n_fail++; $display("FAIL wr_busy_wait: got %b want 0000", req_done); end
        axis_cmdreg_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (req_done !== 4'b0010) begin n_fail++; $display("FAIL wr_done: got %b want 0010", req_done); end
        n_checks++; if (req_err !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %0h want 0", req_err); end
        n_checks++; if (req_rdata !== 32'h0) begin n_fail++; $display("FAIL wr_rdata: got %h want 0", req_rdata); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_idle: got %0h want 0", busy); end
        n_checks++; if (cmd_cnt - cnt0 !== 1) begin n_fail++; $display("FAIL wr_cmd_count: got %0d want 1", cmd_cnt - cnt0); end
    endtask

    // Read on requester 0 that never gets an interrupt
    task automatic test_timeout();
        int cyc;
        req_data[31:0] = 32'h9400_0020; req_valid = 4'b0001; axis_cmdreg_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL to_req_ready: got %b want 0001", req_ready); end
        @(negedge clk); req_valid = '0;
        @(negedge clk); axis_cmdreg_ready = 1'b0;
        // 255 cycles in ST_WAIT_RD; req_done is seen on the 256th falling edge
        cyc = 1;
        while (req_done === 4'b0000 && cyc < 400) begin @(negedge clk); cyc++; end
        n_checks++; if (cyc !== 256) begin n_fail++; $display("FAIL to_latency: got %0d want 256", cyc); end
        n_checks++; if (req_done !== 4'b0001) begin n_fail++; $display("FAIL to_done: got %b want 0001", req_done); end
        n_checks++; if (req_err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %0h want 1", req_err); end
        n_checks++; if (req_rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL to_rdata: got %h want ffffffff", req_rdata); end
        @(negedge clk);
        axis_rbdata_data = 32'h0000_0055; int_valid = 1'b1;
        #1;
        n_checks++; if (int_ready !== 1'b1) begin n_fail++; $display("FAIL to_stray_ack: got %0h want 1", int_ready); end
        @(negedge clk); int_valid = 1'b0;
        n_checks++; if (req_done !== 4'b0000) begin n_fail++; $display("FAIL to_stray_done: got %b want 0000", req_done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL to_stray_busy: got %0h want 0", busy); end
        n_checks++; if (req_rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL to_stray_rdata: got %h want ffffffff", req_rdata); end
    endtask

    // All four requesters held valid after reset; writes with DME always ready.
    // Each write spans ISSUE, two WAIT cycles, DONE, IDLE: commands 5 cycles apart.
    task automatic test_round_robin();
        int exp_idx [5] = '{0, 1, 2, 3, 0};
        int n_grant, n_cmd, cyc, last_cyc;
        logic [3:0] want;
        reset = 1'b1; req_valid = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) req_data[32*i +: 32] = 32'h0A00_0000 | 32'(i);
        axis_cmdreg_ready = 1'b1; int_valid = 1'b0;
        req_valid = 4'b1111;
        n_grant = 0; n_cmd = 0; cyc = 0; last_cyc = 0;
        while (n_cmd < 5 && cyc < 200) begin
            #1;
            if (req_ready !== 4'b0000 && n_grant < 5) begin
                want = 4'b0001 << exp_idx[n_grant];
                n_checks++; if (req_ready !== want) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", n_grant, req_ready, want); end
                n_grant++;
            end
            if (axis_cmdreg_valid === 1'b1) begin
                n_checks++; if (axis_cmdreg_data !== (32'h0A00_0000 | 32'(exp_idx[n_cmd]))) begin n_fail++; $display("FAIL rr_cmd%0d: got %h want %h", n_cmd, axis_cmdreg_data, 32'h0A00_0000 | 32'(exp_idx[n_cmd])); end
                if (n_cmd > 0) begin
                    n_checks++; if (cyc - last_cyc !== 5) begin n_fail++; $display("FAIL rr_spacing%0d: got %0d want 5", n_cmd, cyc - last_cyc); end
                end
                last_cyc = cyc;
                n_cmd++;
            end
            @(negedge clk); cyc++;
        end
        n_checks++; if (n_grant !== 5) begin n_fail++; $display("FAIL rr_grant_count: got %0d want 5", n_grant); end
        n_checks++; if (n_cmd !== 5) begin n_fail++; $display("FAIL rr_cmd_count: got %0d want 5", n_cmd); end
        req_valid = '0;
        repeat (6) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_idle: got %0h want 0", busy); end
    endtask

    // Reset while waiting for read data; then requester 0 wins over 2
    task automatic test_reset_mid();
        int cyc;
        req_data[95:64] = 32'h9400_0010; req_valid = 4'b0100; axis_cmdreg_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL rm_req_ready: got %b want 0100", req_ready); end
        @(negedge clk); req_valid = '0;
        @(negedge clk); axis_cmdreg_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rm_busy_before: got %0h want 1", busy); end
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %0h want 0", busy); end
        n_checks++; if (axis_cmdreg_valid !== 1'b0) begin n_fail++; $display("FAIL rm_cmd_valid: got %0h want 0", axis_cmdreg_valid); end
        n_checks++; if (req_done !== 4'b0000) begin n_fail++; $display("FAIL rm_done: got %b want 0000", req_done); end
        n_checks++; if (req_rdata !== 32'h0) begin n_fail++; $display("FAIL rm_rdata: got %h want 0", req_rdata); end
        reset = 1'b0;
        req_data[31:0] = 32'h0C00_0001; req_valid = 4'b0101; axis_cmdreg_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rm_first_grant: got %b want 0001", req_ready); end
        @(negedge clk); req_valid = '0;
        n_checks++; if (cur_grant !== 2'd0) begin n_fail++; $display("FAIL rm_cur_grant: got %0d want 0", cur_grant); end
        cyc = 0;
        while (req_done === 4'b0000 && cyc < 50) begin @(negedge clk); cyc++; end
        n_checks++; if (req_done !== 4'b0001) begin n_fail++; $display("FAIL rm_done_after: got %b want 0001", req_done); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_error_readback();
        test_single_write();
        test_timeout();
        test_round_robin();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
